// File: rtl/spi_mem_slave_burst.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_slave_burst
// Brief    : SPI-slave front end with internal single-port RAM, burst access
//            and frame-abort flag. One clk edge carries one serial bit.
// Revision : 1.0  initial release
// ============================================================================
module spi_mem_slave_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);
    localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CW-1:0]         LAST_BIT    = CW'(PW - 1);
    localparam logic [CW-1:0]         LAST_RD_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(MEM_DEPTH - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_WR_ADDR = 3'd2;
    localparam logic [2:0] ST_WR_DATA = 3'd3;
    localparam logic [2:0] ST_RD_ADDR = 3'd4;
    localparam logic [2:0] ST_RD_DATA = 3'd5;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic [2:0]            state_q,  state_d;
    logic                  cmd_hi_q, cmd_hi_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [PW-1:0]         sh_q,     sh_d;
    logic                  done_q,   done_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_sh_q,  rd_sh_d;
    logic                  miso_q,   miso_d;
    logic                  busy_q;
    logic                  ferr_q,   ferr_d;

    logic                  mem_we;
    logic [PW-1:0]         payload;
    logic [DATA_WIDTH-1:0] rd_word;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] p);
        return int'(p) < MEM_DEPTH;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    assign payload = {sh_q[PW-2:0], MOSI};
    // Out-of-range pointers read back as zeros rather than aliasing.
    assign rd_word = in_range(rd_ptr_q) ? mem[rd_ptr_q[MW-1:0]] : '0;

    always_comb begin
        state_d  = state_q;
        cmd_hi_d = cmd_hi_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_sh_d  = rd_sh_q;
        miso_d   = 1'b0;
        ferr_d   = 1'b0;
        mem_we   = 1'b0;
        if (SS_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            if (state_q == ST_CMD) begin
                ferr_d = 1'b1;
            end else if ((state_q == ST_WR_ADDR || state_q == ST_WR_DATA ||
                          state_q == ST_RD_ADDR) && !done_q && cnt_q != '0) begin
                ferr_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_CMD;
                    cmd_hi_d = MOSI;
                end
                ST_CMD: begin
                    cnt_d  = '0;
                    done_d = 1'b0;
                    case ({cmd_hi_q, MOSI})
                        2'b00:   state_d = ST_WR_ADDR;
                        2'b01:   state_d = ST_WR_DATA;
                        2'b10:   state_d = ST_RD_ADDR;
                        default: state_d = ST_RD_DATA;
                    endcase
                end
                ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR: begin
                    if (!done_q) begin
                        sh_d = payload;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d = '0;
                            if (state_q == ST_WR_ADDR) begin
                                wr_ptr_d = payload[ADDR_WIDTH-1:0];
                                done_d   = 1'b1;
                            end else if (state_q == ST_RD_ADDR) begin
                                rd_ptr_d = payload[ADDR_WIDTH-1:0];
                                done_d   = 1'b1;
                            end else begin
                                mem_we = in_range(wr_ptr_q);
                                if (AUTO_INC) begin
                                    wr_ptr_d = ptr_inc(wr_ptr_q);
                                end else begin
                                    done_d = 1'b1;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Word boundary: fetch and present MSB on the same edge, no gap.
                    if (cnt_q == '0) begin
                        miso_d  = rd_word[DATA_WIDTH-1];
                        rd_sh_d = rd_word << 1;
                        if (AUTO_INC) begin
                            rd_ptr_d = ptr_inc(rd_ptr_q);
                        end
                    end else begin
                        miso_d  = rd_sh_q[DATA_WIDTH-1];
                        rd_sh_d = rd_sh_q << 1;
                    end
                    cnt_d = (cnt_q == LAST_RD_BIT) ? '0 : cnt_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_hi_q <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_sh_q  <= '0;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_hi_q <= cmd_hi_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_sh_q  <= rd_sh_d;
            miso_q   <= miso_d;
            busy_q   <= (state_d != ST_IDLE);
            ferr_q   <= ferr_d;
        end
    end

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wr_ptr_q[MW-1:0]] <= payload[DATA_WIDTH-1:0];
        end
    end

    assign MISO      = miso_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_slave_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_slave_burst
// Brief    : Directed self-checking bench for spi_mem_slave_burst.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_mem_slave_burst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_a = 1'b1, mosi_a = 1'b0, ss_b = 1'b1, mosi_b = 1'b0;
    logic miso_a, busy_a, ferr_a;
    logic miso_b, busy_b, ferr_b;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    spi_mem_slave_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .SS_n(ss_a), .MOSI(mosi_a),
        .MISO(miso_a), .busy(busy_a), .frame_err(ferr_a)
    );

    spi_mem_slave_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi_b),
        .MISO(miso_b), .busy(busy_b), .frame_err(ferr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bit-clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input int d, input logic ss, input logic mosi, output logic miso);
        @(negedge clk);
        if (d == 0) begin ss_a = ss; mosi_a = mosi; end
        else        begin ss_b = ss; mosi_b = mosi; end
        @(posedge clk);
        #1;
        miso = (d == 0) ? miso_a : miso_b;
    endtask

    task automatic send(input int d, input logic [31:0] val, input int n);
        logic m;
        for (int i = n - 1; i >= 0; i--) cyc(d, 1'b0, val[i], m);
    endtask

    task automatic idle(input int d);
        logic m;
        cyc(d, 1'b1, 1'b0, m);
    endtask

    task automatic rd(input int d, input int n, output logic [31:0] val);
        logic m;
        val = '0;
        for (int i = 0; i < n; i++) begin
            cyc(d, 1'b0, 1'b0, m);
            val = {val[30:0], m};
        end
    endtask

    task automatic frame(input int d, input logic [1:0] cmd, input logic [7:0] pl);
        send(d, {22'd0, cmd, pl}, 10);
        idle(d);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", {31'd0, miso_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_ferr", {31'd0, ferr_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single write then single read
        frame(0, 2'b00, 8'h10);
        frame(0, 2'b01, 8'hA5);
        chk("wr_done_noerr", {31'd0, ferr_a}, 32'd0);
        frame(0, 2'b10, 8'h10);
        send(0, 32'b11, 2);
        chk("busy_in_cmd", {31'd0, busy_a}, 32'd1);
        rd(0, 8, v);
        chk("rd_A5", v, 32'hA5);
        idle(0);
        chk("miso_after_rd", {31'd0, miso_a}, 32'd0);
        chk("busy_after_rd", {31'd0, busy_a}, 32'd0);

        // 2: burst write with wrap FE,FF,00
        frame(0, 2'b00, 8'hFE);
        send(0, {22'd0, 2'b01, 8'h11}, 10);
        send(0, 32'h22, 8);
        send(0, 32'h33, 8);
        idle(0);
        chk("burst_wr_noerr", {31'd0, ferr_a}, 32'd0);

        // 3: gapless burst read from FE
        frame(0, 2'b10, 8'hFE);
        send(0, 32'b11, 2);
        rd(0, 24, v);
        chk("burst_rd", v, 32'h112233);
        idle(0);

        // 4: aborted frames
        frame(0, 2'b00, 8'h40);
        frame(0, 2'b01, 8'h3C);
        send(0, {25'd0, 2'b01, 5'b10101}, 7);
        idle(0);
        chk("abort_ferr", {31'd0, ferr_a}, 32'd1);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        idle(0);
        chk("abort_pulse_1cyc", {31'd0, ferr_a}, 32'd0);
        send(0, 32'b1, 1);
        idle(0);
        chk("cmd_abort_ferr", {31'd0, ferr_a}, 32'd1);
        frame(0, 2'b01, 8'h77);
        frame(0, 2'b10, 8'h40);
        send(0, 32'b11, 2);
        rd(0, 16, v);
        chk("abort_no_side_effect", v, 32'h3C77);
        idle(0);

        // 5: reset mid RD_DATA
        frame(0, 2'b10, 8'h10);
        send(0, 32'b11, 2);
        rd(0, 3, v);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_miso", {31'd0, miso_a}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        ss_a = 1'b1;
        idle(0);
        send(0, 32'b11, 2);
        rd(0, 8, v);
        chk("rd_ptr_reset", v, 32'h33);
        idle(0);
        frame(0, 2'b10, 8'h00);
        send(0, 32'b11, 2);
        rd(0, 8, v);
        chk("rd_mem0", v, 32'h33);
        idle(0);
        frame(0, 2'b01, 8'h99);
        frame(0, 2'b10, 8'h00);
        send(0, 32'b11, 2);
        rd(0, 8, v);
        chk("wr_ptr_reset", v, 32'h99);
        idle(0);

        // 6: AUTO_INC=0 repeats the same word, extra write bits ignored
        frame(1, 2'b00, 8'h05);
        send(1, {22'd0, 2'b01, 8'h5A}, 10);
        send(1, 32'h77, 8);
        idle(1);
        chk("noinc_extra_noerr", {31'd0, ferr_b}, 32'd0);
        frame(1, 2'b10, 8'h05);
        send(1, 32'b11, 2);
        rd(1, 16, v);
        chk("noinc_repeat", v, 32'h5A5A);
        idle(1);
        chk("noinc_busy_idle", {31'd0, busy_b}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
